// File: rtl/rv32_pkg.sv
// Shared RV32 constants used by the front-end blocks: datapath width,
// the canonical NOP encoding and the width of an instruction-queue entry.
package rv32_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Each queue entry holds {pc, instr}.
  function automatic int entry_w(input int xlen);
    return 2 * xlen;
  endfunction

  localparam int ENTRY_W = entry_w(XLEN);

endpackage

// File: rtl/ifq_mem.sv
// Entry storage for the instruction fetch queue: a register array with
// one synchronous write port and one combinational read port.
module ifq_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; validity is tracked by the
  // level counter in ifq, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ifq.sv
// Instruction fetch queue between fetch and decode: registered-state ready,
// one-cycle push-to-valid latency, flush on redirect, NOP when empty.
module ifq
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = rv32_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = entry_w(XLEN);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic [EW-1:0] head_entry;

  // Ready depends only on the registered count, never on out_ready, so a
  // full queue rejects a push even while its head is being popped.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = count;

  ifq_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (tail),
    .wdata ({in_pc, in_instr}),
    .raddr (head),
    .rdata (head_entry)
  );

  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge values of head/tail/count regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_pc    = out_valid ? head_entry[EW-1:XLEN] : '0;
  assign out_instr = out_valid ? head_entry[XLEN-1:0]  : XLEN'(NOP);

endmodule

// File: tb/tb_ifq.sv
// Directed self-checking bench for ifq: reset, fill, drain, streaming wrap,
// flush race, full-plus-pop and mid-traffic reset.
module tb_ifq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        flush;
  logic [2:0]  level;

  int n_cmp = 0;
  int n_err = 0;

  ifq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .flush     (flush),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_level",     level,     3'd0);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_instr", out_instr, 32'h13);
    check("rst_out_pc",    out_pc,    32'h0);
    rst_n = 1'b1;

    // Fill: pc 0,4,8,12 / instr A0..A3, decode stalled.
    drive(1'b1, 32'h0, 32'hA0, 1'b0, 1'b0);
    check("fill_no_bypass", out_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0);
      tick();
      if (i == 0) begin
        check("fill_latency_valid", out_valid, 1'b1);
        check("fill_latency_pc",    out_pc,    32'h0);
      end
    end
    check("fill_level",    level,    3'd4);
    check("fill_in_ready", in_ready, 1'b0);
    drive(1'b1, 32'h10, 32'hA4, 1'b0, 1'b0);
    tick();
    check("fill_5th_level", level,     3'd4);
    check("fill_head_pc",   out_pc,    32'h0);
    check("fill_head_ins",  out_instr, 32'hA0);

    // Drain in FIFO order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("drain_pc",  out_pc,    32'(4 * i));
      check("drain_ins", out_instr, 32'hA0 + 32'(i));
      tick();
    end
    check("drain_out_valid", out_valid, 1'b0);
    check("drain_out_instr", out_instr, 32'h13);
    check("drain_out_pc",    out_pc,    32'h0);
    check("drain_level",     level,     3'd0);
    tick();
    check("empty_pop_ignored", level, 3'd0);

    // Streaming at level 1 for 20 cycles; pointers wrap five times.
    drive(1'b1, 32'h100, 32'h1000, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 32'h104 + 32'(4 * k), 32'h1001 + 32'(k), 1'b1, 1'b0);
      check("stream_level", level,     3'd1);
      check("stream_pc",    out_pc,    32'h100 + 32'(4 * k));
      check("stream_ins",   out_instr, 32'h1000 + 32'(k));
      tick();
    end
    check("stream_end_level", level,  3'd1);
    check("stream_end_pc",    out_pc, 32'h150);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check("stream_drained", level, 3'd0);

    // Flush race at level 2 with simultaneous push and pop.
    drive(1'b1, 32'h20, 32'h20, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h24, 32'h24, 1'b0, 1'b0);
    tick();
    check("flush_pre_level", level, 3'd2);
    drive(1'b1, 32'h40, 32'h40, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("flush_level",     level,     3'd0);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_out_instr", out_instr, 32'h13);
    drive(1'b1, 32'h80, 32'h80, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("postflush_valid", out_valid, 1'b1);
    check("postflush_pc",    out_pc,    32'h80);
    check("postflush_level", level,     3'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check("postflush_empty", level, 3'd0);

    // Full plus pop: push rejected, then accepted next cycle at level 3.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 32'hB0 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h210, 32'hB4, 1'b1, 1'b0);
    check("fullpop_in_ready", in_ready, 1'b0);
    tick();
    check("fullpop_level", level,  3'd3);
    check("fullpop_head",  out_pc, 32'h204);
    check("retry_ready",   in_ready, 1'b1);
    tick();
    check("retry_level", level,  3'd3);
    check("retry_head",  out_pc, 32'h208);
    for (int i = 2; i < 5; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("retry_drain_pc",  out_pc,    32'h200 + 32'(4 * i));
      check("retry_drain_ins", out_instr, 32'hB0 + 32'(i));
      tick();
    end
    check("retry_empty", level, 3'd0);

    // Asynchronous reset mid-traffic at level 3.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("arst_pre_level", level, 3'd3);
    rst_n = 1'b0;
    #1;
    check("arst_level",     level,     3'd0);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_instr", out_instr, 32'h13);
    check("arst_in_ready",  in_ready,  1'b1);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 32'h400, 32'hD0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("arst_first_push_valid", out_valid, 1'b1);
    check("arst_first_push_pc",    out_pc,    32'h400);
    check("arst_first_push_level", level,     3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
